psk_modulator: RTL and testbench

- BPSK transmitter, the counterpart of the PSK correlator receiver chain.
- Accepts bytes over a valid/ready handshake and frames them behind a sync byte.
- Serializes each frame MSB first, one bit per symbol period, onto an NCO-derived square-wave carrier.
- Drives the 1-bit `sig` line that the receiver correlates against its I/Q NCO codes.

---
 rtl/psk_modulator.sv | 217 +++++++++++++++++++++
 tb/tb_psk_modulator.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psk_modulator.sv
// -----------------------------------------------------------------------------
// psk_modulator
//
// BPSK transmitter. Bytes arrive over a valid/ready handshake into a
// single-entry holding register. Each frame starts with SYNC_WORD and is
// followed by one or more data bytes. The frame is serialized MSB first at one
// bit per symbol period, and each bit inverts or passes an NCO-derived
// square-wave carrier.
//
// Ports:
//   clk     in   system clock
//   rst_in  in   asynchronous active-low reset
//   fcw     in   carrier frequency control word, accumulated every cycle
//   data    in   byte to transmit
//   valid   in   data valid; a transfer happens when valid && ready
//   ready   out  holding register empty
//   sig     out  registered modulated carrier (carrier ^ symbol)
//   busy    out  frame in progress (state != IDLE)
//   done    out  one-cycle pulse after the last symbol boundary of a frame
// -----------------------------------------------------------------------------
module psk_modulator #(
    parameter int         SYM_CYCLES = 64,
    parameter logic [7:0] SYNC_WORD  = 8'hA5,
    parameter int         FCW_W      = 13
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [FCW_W-1:0] fcw,
    input  logic [7:0]       data,
    input  logic             valid,
    output logic             ready,
    output logic             sig,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = $clog2(SYM_CYCLES);
    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [FCW_W-1:0] r_phase;
    logic [CNT_W-1:0] r_sym_cnt;

    logic [7:0]       r_hold;
    logic             r_hold_full;

    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic             r_sym;
    logic             w_sym_next;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_cnt_next;

    logic             r_sig;
    logic             r_done;
    logic             w_done_next;
    logic             w_load;

    logic             w_boundary;
    logic             w_last_bit;
    logic             w_xfer;
    logic             w_carrier;

    assign w_boundary = (r_sym_cnt == SYM_LAST);
    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign w_xfer     = valid && !r_hold_full;
    assign w_carrier  = r_phase[FCW_W-1];

    assign ready = !r_hold_full;
    assign busy  = (r_state != ST_IDLE);
    assign sig   = r_sig;
    assign done  = r_done;

    // -------------------------------------------------------------------------
    // Carrier NCO and symbol grid: both free-run in every state so that a
    // frame always starts on a symbol boundary.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_phase   <= '0;
            r_sym_cnt <= '0;
        end else begin
            r_phase   <= r_phase + fcw;
            r_sym_cnt <= w_boundary ? '0 : r_sym_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. Transitions only happen on a symbol boundary.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (w_boundary) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_hold_full) begin
                        w_state_next = ST_SYNC;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    // The byte held since IDLE guarantees SYNC always moves
                    // on to DATA; in DATA an empty hold ends the frame.
                    if (w_last_bit) begin
                        w_state_next = r_hold_full ? ST_DATA : ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs - next shift/symbol/bit count, hold load and done pulse.
    // -------------------------------------------------------------------------
    always_comb begin
        w_shift_next   = r_shift;
        w_sym_next     = r_sym;
        w_bit_cnt_next = r_bit_cnt;
        w_load         = 1'b0;
        w_done_next    = 1'b0;
        if (w_boundary) begin
            case (r_state)
                ST_IDLE: begin
                    // The held byte stays put; it is loaded after the sync byte.
                    if (r_hold_full) begin
                        w_shift_next   = SYNC_WORD;
                        w_sym_next     = SYNC_WORD[7];
                        w_bit_cnt_next = 3'd0;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    if (!w_last_bit) begin
                        w_shift_next   = {r_shift[6:0], 1'b0};
                        w_sym_next     = r_shift[6];
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end else if (r_hold_full) begin
                        w_load         = 1'b1;
                        w_shift_next   = r_hold;
                        w_sym_next     = r_hold[7];
                        w_bit_cnt_next = 3'd0;
                    end else begin
                        w_shift_next   = 8'h00;
                        w_sym_next     = 1'b0;
                        w_bit_cnt_next = 3'd0;
                        w_done_next    = 1'b1;
                    end
                end
                default: begin
                    w_sym_next = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Holding register. A transfer and a load in the same cycle leave the new
    // byte in hold with hold_full still set; the load reads the old byte.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_hold <= data;
            end
            if (w_xfer) begin
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Serializer, output register and done pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_shift   <= 8'h00;
            r_sym     <= 1'b0;
            r_bit_cnt <= 3'd0;
            r_sig     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_shift   <= w_shift_next;
            r_sym     <= w_sym_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_sig     <= w_carrier ^ r_sym;
            r_done    <= w_done_next;
        end
    end

endmodule

// File: tb/tb_psk_modulator.sv
// -----------------------------------------------------------------------------
// tb_psk_modulator
//
// Directed bench for psk_modulator with SYM_CYCLES=64 and fcw=13'h0100, which
// gives a 32-cycle carrier. After n clock edges since reset release the
// phase is n*256 mod 8192, so the carrier during cycle n is (n % 32) >= 16.
// Because sig is registered, the sample taken after edge n shows
// carrier(n-1) ^ sym(n-1).
// -----------------------------------------------------------------------------
module tb_psk_modulator;

    localparam int         SYM   = 64;
    localparam int         FCW_W = 13;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic             clk    = 1'b0;
    logic             rst_in = 1'b0;
    logic [FCW_W-1:0] fcw    = 13'h0100;
    logic [7:0]       data   = 8'h00;
    logic             valid  = 1'b0;
    logic             ready;
    logic             sig;
    logic             busy;
    logic             done;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;   // clock edges since reset release
    int done_cnt = 0;   // done pulses seen since time zero

    // Expected frame bits, MSB first: sync byte in [31:24], data bytes below.
    logic [31:0] exp_frame = 32'h0;

    always #5 clk = ~clk;

    psk_modulator #(
        .SYM_CYCLES (SYM),
        .SYNC_WORD  (SYNC),
        .FCW_W      (FCW_W)
    ) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .fcw    (fcw),
        .data   (data),
        .valid  (valid),
        .ready  (ready),
        .sig    (sig),
        .busy   (busy),
        .done   (done)
    );

    always @(posedge clk or negedge rst_in) begin
        if (!rst_in) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic carr(input int n);
        return ((n % 32) >= 16);
    endfunction

    // Present one byte from a negedge and hold it until the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        bit sent;
        sent = 0;
        for (int k = 0; k < 3000 && !sent; k++) begin
            valid = 1'b1;
            data  = b;
            if (ready) begin
                @(posedge clk);
                sent = 1;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        checks++;
        if (!sent) begin
            errors++;
            $display("FAIL send_byte timeout: byte %h not accepted, ready=%b expected 1", b, ready);
        end
    endtask

    // Waits for a frame to start, then checks every symbol of it against
    // exp_frame, plus grid alignment, busy length and the done pulse.
    task automatic check_frame(input string name, input int nsym);
        bit   started;
        bit   bad;
        int   b0;
        int   busy_cnt;
        logic exp_bit;
        logic exp_sig;
        logic bad_sig;
        started = 0;
        for (int k = 0; k < 2000 && !started; k++) begin
            @(negedge clk);
            if (busy === 1'b1) started = 1;
        end
        checks++;
        if (!started) begin
            errors++;
            $display("FAIL %s start: busy=%b expected 1 within 2000 cycles", name, busy);
            return;
        end
        b0 = cyc;
        checks++;
        if ((b0 % SYM) != 0) begin
            errors++;
            $display("FAIL %s grid: frame started at edge %0d, expected a multiple of %0d", name, b0, SYM);
        end
        busy_cnt = 1;
        for (int i = 0; i < nsym; i++) begin
            bad     = 0;
            bad_sig = 1'b0;
            exp_bit = exp_frame[31-i];
            for (int j = 0; j < SYM; j++) begin
                @(negedge clk);
                exp_sig = carr(cyc - 1) ^ exp_bit;
                if (sig !== exp_sig && !bad) begin
                    bad     = 1;
                    bad_sig = sig;
                end
                if (busy === 1'b1) busy_cnt++;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s symbol %0d: sig=%b expected carrier^%b (%b)", name, i, bad_sig,
                         exp_bit, ~bad_sig);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end: done=%b busy=%b expected done=1 busy=0", name, done, busy);
        end
        checks++;
        if (busy_cnt != nsym * SYM) begin
            errors++;
            $display("FAIL %s busy length: %0d cycles expected %0d", name, busy_cnt, nsym * SYM);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done width: done=%b one cycle later, expected 0", name, done);
        end
    endtask

    task automatic test_reset;
        int bad;
        int highs;
        int d0;
        repeat (40) @(negedge clk);
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if (sig !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: sig=%b ready=%b busy=%b done=%b expected 0 1 0 0",
                     sig, ready, busy, done);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (sig !== 1'b0) begin
            errors++;
            $display("FAIL reset hold sig: sig=%b expected 0", sig);
        end
        #3 rst_in = 1'b1;
        d0    = done_cnt;
        bad   = 0;
        highs = 0;
        for (int k = 0; k < 96; k++) begin
            @(negedge clk);
            if (sig !== carr(cyc - 1) || ready !== 1'b1 || busy !== 1'b0) bad++;
            if (k >= 40 && k < 72 && sig === 1'b1) highs++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle carrier: %0d bad samples expected 0", bad);
        end
        checks++;
        if (highs != 16) begin
            errors++;
            $display("FAIL idle duty: %0d high of 32 expected 16", highs);
        end
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL idle done: %0d pulses expected 0", done_cnt - d0);
        end
    endtask

    task automatic test_single;
        int d0;
        d0 = done_cnt;
        exp_frame = {SYNC, 8'h3C, 16'h0000};
        send_byte(8'h3C);
        check_frame("single", 16);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL single done count: %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = done_cnt;
        exp_frame = {SYNC, 8'hFF, 8'h00, 8'h81};
        fork
            check_frame("b2b", 32);
            begin
                send_byte(8'hFF);
                send_byte(8'h00);
                send_byte(8'h81);
            end
        join
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL b2b done count: %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_underrun;
        int d0;
        d0 = done_cnt;
        exp_frame = {SYNC, 8'hC3, 16'h0000};
        send_byte(8'hC3);
        fork
            check_frame("underrun1", 16);
            begin
                bit seen;
                seen = 0;
                for (int k = 0; k < 3000 && !seen; k++) begin
                    @(negedge clk);
                    if (done === 1'b1) seen = 1;
                end
                checks++;
                if (!seen) begin
                    errors++;
                    $display("FAIL underrun done wait: done=%b expected 1", done);
                end
                @(negedge clk);
                send_byte(8'h96);
            end
        join
        exp_frame = {SYNC, 8'h96, 16'h0000};
        check_frame("underrun2", 16);
        checks++;
        if (done_cnt - d0 != 2) begin
            errors++;
            $display("FAIL underrun done count: %0d expected 2", done_cnt - d0);
        end
    endtask

    task automatic test_backpressure;
        exp_frame = {SYNC, 8'h5A, 16'h0000};
        send_byte(8'h5A);
        fork
            check_frame("backpressure", 24);
            begin
                bit         sent;
                int         waited;
                logic [7:0] cap;
                sent   = 0;
                waited = 0;
                cap    = 8'h00;
                for (int k = 0; k < 3000 && !sent; k++) begin
                    valid = 1'b1;
                    data  = 8'(8'h21 + k * 7);
                    if (ready) begin
                        cap = data;
                        exp_frame[15:8] = cap;
                        @(posedge clk);
                        sent = 1;
                    end else begin
                        waited++;
                    end
                    @(negedge clk);
                end
                valid = 1'b0;
                checks++;
                if (!sent || waited < 2) begin
                    errors++;
                    $display("FAIL backpressure wait: sent=%b waited=%0d expected sent=1 waited>=2",
                             sent, waited);
                end
            end
        join
    endtask

    task automatic test_reset_mid_data;
        bit started;
        int b0;
        int d0;
        int bad;
        exp_frame = {SYNC, 8'hE7, 16'h0000};
        send_byte(8'hE7);
        started = 0;
        for (int k = 0; k < 2000 && !started; k++) begin
            @(negedge clk);
            if (busy === 1'b1) started = 1;
        end
        b0 = cyc;
        checks++;
        if (!started) begin
            errors++;
            $display("FAIL rstmid start: busy=%b expected 1", busy);
        end
        send_byte(8'h55);
        while (cyc < b0 + 11 * SYM + 20 && cyc < 100000) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid pre: busy=%b ready=%b expected 1 0", busy, ready);
        end
        d0 = done_cnt;
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if (sig !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid outputs: sig=%b ready=%b busy=%b done=%b expected 0 1 0 0",
                     sig, ready, busy, done);
        end
        repeat (3) @(negedge clk);
        #4 rst_in = 1'b1;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid held byte lost: %0d cycles busy or not ready, expected 0", bad);
        end
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL rstmid done: %0d pulses expected 0", done_cnt - d0);
        end
        exp_frame = {SYNC, 8'h18, 16'h0000};
        send_byte(8'h18);
        check_frame("rstmid_next", 16);
    endtask

    initial begin
        #23 rst_in = 1'b1;
        test_reset();
        @(negedge clk);
        test_single();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_underrun();
        @(negedge clk);
        test_backpressure();
        @(negedge clk);
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
